// File: rtl/bcd_add_datapath.sv
// BCD adder datapath: responder side of the request/acknowledge handshake.
// Each request line gets its own 4-phase ACK. Operands load from SW, and ADD runs
// digit-serially, one digit per clock. Display ops copy a register into DISP_DATA.
module bcd_add_datapath #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [4*DIGITS-1:0]   SW,
  input  logic                  BCD_INIT,
  output logic                  BCD_INIT_ACK,
  input  logic                  BCD_LOAD_A,
  output logic                  BCD_LOAD_A_ACK,
  input  logic                  BCD_LOAD_B,
  output logic                  BCD_LOAD_B_ACK,
  input  logic                  BCD_DISPLAY_A,
  output logic                  BCD_DISPLAY_A_ACK,
  input  logic                  BCD_DISPLAY_B,
  output logic                  BCD_DISPLAY_B_ACK,
  input  logic                  BCD_ADD,
  output logic                  BCD_ADD_ACK,
  input  logic                  BCD_DISPLAY_RESULT_LS,
  output logic                  BCD_DISPLAY_RESULT_LS_ACK,
  input  logic                  BCD_DISPLAY_RESULT_MS,
  output logic                  BCD_DISPLAY_RESULT_MS_ACK,
  output logic [4*DIGITS-1:0]   DISP_DATA,
  output logic                  BCD_ERR
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned CntW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(DIGITS - 1);

  // Bit positions in the request vector; lower index = higher priority.
  localparam int unsigned ReqInit   = 0;
  localparam int unsigned ReqLoadA  = 1;
  localparam int unsigned ReqLoadB  = 2;
  localparam int unsigned ReqAdd    = 3;
  localparam int unsigned ReqDispA  = 4;
  localparam int unsigned ReqDispB  = 5;
  localparam int unsigned ReqDispLs = 6;
  localparam int unsigned ReqDispMs = 7;

  typedef enum logic [1:0] {StIdle, StAddRun, StAckWait} state_e;

  state_e          state_q;
  logic [7:0]      sel_q;
  logic [7:0]      ack_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W+3:0]    res_q;
  logic [W-1:0]    disp_q;
  logic            err_q;
  logic            carry_q;
  logic [CntW-1:0] digit_q;

  logic [7:0]      req;
  logic [7:0]      grant;
  logic            sw_bad;
  logic [3:0]      a_dig;
  logic [3:0]      b_dig;
  logic [4:0]      digit_sum;
  logic [3:0]      sum_dig;
  logic            carry_n;

  assign req = {BCD_DISPLAY_RESULT_MS, BCD_DISPLAY_RESULT_LS, BCD_DISPLAY_B, BCD_DISPLAY_A,
                BCD_ADD, BCD_LOAD_B, BCD_LOAD_A, BCD_INIT};

  // Fixed-priority pick: scan from lowest priority so the highest set request wins.
  always_comb begin
    grant = '0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end

  // Flag any switch nibble outside 0..9.
  always_comb begin
    sw_bad = 1'b0;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (SW[4*d +: 4] > 4'd9) sw_bad = 1'b1;
    end
  end

  // One BCD digit of the serial add; invalid digits go through the same correction.
  always_comb begin
    a_dig     = a_q[{digit_q, 2'b00} +: 4];
    b_dig     = b_q[{digit_q, 2'b00} +: 4];
    digit_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
    if (digit_sum > 5'd9) begin
      sum_dig = digit_sum[3:0] + 4'd6;
      carry_n = 1'b1;
    end else begin
      sum_dig = digit_sum[3:0];
      carry_n = 1'b0;
    end
  end

  // Control FSM with registered datapath and ACK outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      sel_q   <= '0;
      ack_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      digit_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|grant) begin
            sel_q <= grant;
            if (grant[ReqAdd]) begin
              res_q   <= '0;
              carry_q <= 1'b0;
              digit_q <= '0;
              state_q <= StAddRun;
            end else begin
              ack_q   <= grant;
              state_q <= StAckWait;
            end
            if (grant[ReqInit]) begin
              a_q    <= '0;
              b_q    <= '0;
              res_q  <= '0;
              disp_q <= '0;
              err_q  <= 1'b0;
            end
            if (grant[ReqLoadA]) begin
              a_q <= SW;
              if (sw_bad) err_q <= 1'b1;
            end
            if (grant[ReqLoadB]) begin
              b_q <= SW;
              if (sw_bad) err_q <= 1'b1;
            end
            if (grant[ReqDispA])  disp_q <= a_q;
            if (grant[ReqDispB])  disp_q <= b_q;
            if (grant[ReqDispLs]) disp_q <= res_q[W-1:0];
            if (grant[ReqDispMs]) disp_q <= {{(W-4){1'b0}}, res_q[W+3:W]};
          end
        end
        StAddRun: begin
          res_q[{digit_q, 2'b00} +: 4] <= sum_dig;
          carry_q <= carry_n;
          if (digit_q == LastDigit) begin
            res_q[W +: 4] <= {3'b000, carry_n};
            ack_q         <= sel_q;
            state_q       <= StAckWait;
          end else begin
            digit_q <= digit_q + 1'b1;
          end
        end
        StAckWait: begin
          // Release once the serviced request is seen low.
          if ((req & sel_q) == 8'h00) begin
            ack_q   <= '0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign BCD_INIT_ACK              = ack_q[ReqInit];
  assign BCD_LOAD_A_ACK            = ack_q[ReqLoadA];
  assign BCD_LOAD_B_ACK            = ack_q[ReqLoadB];
  assign BCD_ADD_ACK               = ack_q[ReqAdd];
  assign BCD_DISPLAY_A_ACK         = ack_q[ReqDispA];
  assign BCD_DISPLAY_B_ACK         = ack_q[ReqDispB];
  assign BCD_DISPLAY_RESULT_LS_ACK = ack_q[ReqDispLs];
  assign BCD_DISPLAY_RESULT_MS_ACK = ack_q[ReqDispMs];
  assign DISP_DATA                 = disp_q;
  assign BCD_ERR                   = err_q;

endmodule

// File: tb/tb_bcd_add_datapath.sv
// Directed bench for bcd_add_datapath (DIGITS=2): handshake timing, priority,
// BCD add results, error flag and asynchronous reset.
module tb_bcd_add_datapath;

  localparam logic [7:0] RInit = 8'h01;
  localparam logic [7:0] RLdA  = 8'h02;
  localparam logic [7:0] RLdB  = 8'h04;
  localparam logic [7:0] RAdd  = 8'h08;
  localparam logic [7:0] RDA   = 8'h10;
  localparam logic [7:0] RDB   = 8'h20;
  localparam logic [7:0] RLs   = 8'h40;
  localparam logic [7:0] RMs   = 8'h80;

  logic       CLK;
  logic       RST;
  logic [7:0] SW;
  logic [7:0] req;
  logic [7:0] ack;
  logic [7:0] DISP_DATA;
  logic       BCD_ERR;

  int passed = 0;
  int total  = 0;

  bcd_add_datapath #(.DIGITS(2)) dut (
    .CLK                       (CLK),
    .RST                       (RST),
    .SW                        (SW),
    .BCD_INIT                  (req[0]),
    .BCD_INIT_ACK              (ack[0]),
    .BCD_LOAD_A                (req[1]),
    .BCD_LOAD_A_ACK            (ack[1]),
    .BCD_LOAD_B                (req[2]),
    .BCD_LOAD_B_ACK            (ack[2]),
    .BCD_ADD                   (req[3]),
    .BCD_ADD_ACK               (ack[3]),
    .BCD_DISPLAY_A             (req[4]),
    .BCD_DISPLAY_A_ACK         (ack[4]),
    .BCD_DISPLAY_B             (req[5]),
    .BCD_DISPLAY_B_ACK         (ack[5]),
    .BCD_DISPLAY_RESULT_LS     (req[6]),
    .BCD_DISPLAY_RESULT_LS_ACK (ack[6]),
    .BCD_DISPLAY_RESULT_MS     (req[7]),
    .BCD_DISPLAY_RESULT_MS_ACK (ack[7]),
    .DISP_DATA                 (DISP_DATA),
    .BCD_ERR                   (BCD_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Raise one request, expect its ACK after one edge, then drop and expect release.
  task automatic serve(input string tag, input logic [7:0] r);
    req = r;
    tick();
    check({tag, "_ack_hi"}, ack, r);
    req = 8'h00;
    tick();
    check({tag, "_ack_lo"}, ack, 8'h00);
  endtask

  // ADD: no ACK for two edges, ACK after the third; DISP_DATA left alone.
  task automatic run_add(input string tag, input logic [7:0] disp_before);
    req = RAdd;
    tick();
    check({tag, "_run1"}, ack, 8'h00);
    tick();
    check({tag, "_run2"}, ack, 8'h00);
    tick();
    check({tag, "_ack"}, ack, RAdd);
    check({tag, "_disp_kept"}, DISP_DATA, disp_before);
    req = 8'h00;
    tick();
    check({tag, "_ack_lo"}, ack, 8'h00);
  endtask

  task automatic load(input string tag, input logic [7:0] r, input logic [7:0] sw);
    SW = sw;
    serve(tag, r);
  endtask

  initial begin
    RST = 1'b1;
    req = 8'h00;
    SW  = 8'h00;
    tick();
    tick();
    check("rst_ack", ack, 8'h00);
    check("rst_disp", DISP_DATA, 8'h00);
    check("rst_err", {7'b0, BCD_ERR}, 8'h00);
    RST = 1'b0;
    tick();

    // INIT handshake
    serve("init", RInit);
    check("init_disp", DISP_DATA, 8'h00);
    check("init_err", {7'b0, BCD_ERR}, 8'h00);

    // LOAD_A then DISPLAY_A raised as LOAD_A drops
    SW  = 8'h45;
    req = RLdA;
    tick();
    check("lda_ack", ack, RLdA);
    req = RDA;
    tick();
    check("lda_release", ack, 8'h00);
    tick();
    check("da_ack", ack, RDA);
    check("da_disp", DISP_DATA, 8'h45);
    req = 8'h00;
    tick();
    check("da_ack_lo", ack, 8'h00);

    // 99 + 99 = 198
    load("ld99a", RLdA, 8'h99);
    load("ld99b", RLdB, 8'h99);
    run_add("add99", 8'h45);
    serve("ls99", RLs);
    check("ls99_disp", DISP_DATA, 8'h98);
    serve("ms99", RMs);
    check("ms99_disp", DISP_DATA, 8'h01);

    // 45 + 37 = 082
    load("ld45", RLdA, 8'h45);
    load("ld37", RLdB, 8'h37);
    run_add("add82", 8'h01);
    serve("ls82", RLs);
    check("ls82_disp", DISP_DATA, 8'h82);
    serve("ms82", RMs);
    check("ms82_disp", DISP_DATA, 8'h00);

    // Invalid digits: FF + FF -> digits 4,5 with carry 1
    load("ldffa", RLdA, 8'hFF);
    load("ldffb", RLdB, 8'hFF);
    check("ff_err", {7'b0, BCD_ERR}, 8'h01);
    run_add("addff", 8'h00);
    serve("lsff", RLs);
    check("lsff_disp", DISP_DATA, 8'h54);
    serve("msff", RMs);
    check("msff_disp", DISP_DATA, 8'h01);

    // Reset in the middle of an ADD
    load("ld12", RLdA, 8'h12);
    req = RAdd;
    tick();
    tick();
    RST = 1'b1;
    tick();
    check("mid_rst_ack", ack, 8'h00);
    check("mid_rst_disp", DISP_DATA, 8'h00);
    check("mid_rst_err", {7'b0, BCD_ERR}, 8'h00);
    req = 8'h00;
    tick();
    RST = 1'b0;
    tick();
    check("post_rst_ack", ack, 8'h00);
    serve("post_rst_da", RDA);
    check("post_rst_a", DISP_DATA, 8'h00);

    // INIT beats ADD; ADD runs after INIT drops, on cleared operands
    load("ld12b", RLdA, 8'h12);
    load("ld34b", RLdB, 8'h34);
    req = RInit | RAdd;
    tick();
    check("prio_init_ack", ack, RInit);
    tick();
    check("prio_init_hold", ack, RInit);
    req = RAdd;
    tick();
    check("prio_init_rel", ack, 8'h00);
    tick();
    check("prio_add_run1", ack, 8'h00);
    tick();
    check("prio_add_run2", ack, 8'h00);
    tick();
    check("prio_add_ack", ack, RAdd);
    req = 8'h00;
    tick();
    check("prio_add_lo", ack, 8'h00);
    serve("prio_ls", RLs);
    check("prio_ls_disp", DISP_DATA, 8'h00);

    // Invalid load sets sticky error; INIT clears it
    load("ld3a", RLdB, 8'h3A);
    check("err_set", {7'b0, BCD_ERR}, 8'h01);
    serve("db3a", RDB);
    check("db3a_disp", DISP_DATA, 8'h3A);
    check("err_sticky", {7'b0, BCD_ERR}, 8'h01);
    serve("init2", RInit);
    check("err_clr", {7'b0, BCD_ERR}, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
